// File: rtl/sram_arbiter.sv
// Two-master Wishbone B4 pipelined arbiter in front of a 16-bit SRAM bridge.
// Round-robin grant held for a whole cycle, with forced yield after a burst limit.
module sram_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int OUT_W     = 3
) (
    input  logic        clk_i,
    input  logic        _reset_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [1:0]  m0_sel_i,
    input  logic [18:0] m0_adr_i,
    input  logic [15:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic [15:0] m0_dat_o,
    output logic        m0_stall_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [1:0]  m1_sel_i,
    input  logic [18:0] m1_adr_i,
    input  logic [15:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic [15:0] m1_dat_o,
    output logic        m1_stall_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [1:0]  s_sel_o,
    output logic [18:0] s_adr_o,
    output logic [15:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [15:0] s_dat_i,
    input  logic        s_stall_i,
    output logic [1:0]  gnt_o
);
    localparam logic [OUT_W-1:0] LIMIT     = {OUT_W{1'b1}};
    localparam logic [OUT_W-1:0] ONE       = OUT_W'(1);
    localparam logic [7:0]       BURST_MAX = 8'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

    state_t           state, state_next;
    logic             owner, owner_next;
    logic             last, last_next;
    logic [OUT_W-1:0] out_cnt, out_next, out_step;
    logic [7:0]       burst_cnt, burst_next, burst_step;
    logic [1:0]       gnt_next;

    logic        active, owning, own_cyc, own_stb, other_cyc;
    logic        yield, hold, accept, ack_in, enter, enter_who;
    logic        own_we;
    logic [1:0]  own_sel;
    logic [18:0] own_adr;
    logic [15:0] own_dat;

    // owner is only meaningful outside IDLE; DRAIN relies on it to remember who drains
    assign active    = (state != IDLE);
    assign owning    = (state == OWN0) || (state == OWN1);
    assign own_cyc   = owner ? m1_cyc_i : m0_cyc_i;
    assign own_stb   = owner ? m1_stb_i : m0_stb_i;
    assign own_we    = owner ? m1_we_i  : m0_we_i;
    assign own_sel   = owner ? m1_sel_i : m0_sel_i;
    assign own_adr   = owner ? m1_adr_i : m0_adr_i;
    assign own_dat   = owner ? m1_dat_i : m0_dat_i;
    assign other_cyc = owner ? m0_cyc_i : m1_cyc_i;

    assign yield  = (burst_cnt == BURST_MAX) && other_cyc;
    assign hold   = (out_cnt == LIMIT) || yield;
    assign accept = s_stb_o && !s_stall_i;
    assign ack_in = s_ack_i && active;

    always_comb begin
        s_cyc_o    = active && own_cyc;
        s_stb_o    = owning && own_stb && !hold;
        s_we_o     = active && own_we;
        s_sel_o    = active ? own_sel : 2'b00;
        s_adr_o    = active ? own_adr : 19'h0;
        s_dat_o    = active ? own_dat : 16'h0;
        m0_stall_o = !(owning && !owner) || s_stall_i || hold;
        m1_stall_o = !(owning && owner) || s_stall_i || hold;
        m0_ack_o   = ack_in && !owner;
        m1_ack_o   = ack_in && owner;
        m0_dat_o   = m0_ack_o ? s_dat_i : 16'h0000;
        m1_dat_o   = m1_ack_o ? s_dat_i : 16'h0000;
    end

    // An accept never coincides with out_cnt==LIMIT because hold blocks the strobe
    always_comb begin
        out_step = out_cnt;
        if (accept && !ack_in)
            out_step = out_cnt + ONE;
        else if (!accept && ack_in && (out_cnt != '0))
            out_step = out_cnt - ONE;
        burst_step = burst_cnt;
        if (accept && (burst_cnt != BURST_MAX))
            burst_step = burst_cnt + 8'd1;
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        last_next  = last;
        out_next   = out_step;
        burst_next = burst_step;
        enter      = 1'b0;
        enter_who  = 1'b0;
        unique case (state)
            IDLE: begin
                if (m0_cyc_i || m1_cyc_i) begin
                    enter     = 1'b1;
                    enter_who = (m0_cyc_i && m1_cyc_i) ? !last : m1_cyc_i;
                end
            end
            OWN0, OWN1, DRAIN: begin
                if (!own_cyc || ((state == DRAIN) &&
                    ((out_cnt == '0) || ((out_cnt == ONE) && s_ack_i)))) begin
                    out_next = '0;
                    if (other_cyc) begin
                        enter     = 1'b1;
                        enter_who = !owner;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (yield) begin
                    state_next = DRAIN;
                end
            end
            default: state_next = IDLE;
        endcase
        if (enter) begin
            state_next = enter_who ? OWN1 : OWN0;
            owner_next = enter_who;
            last_next  = enter_who;
            burst_next = '0;
            out_next   = '0;
        end
        gnt_next = (state_next == IDLE) ? 2'b00 : (owner_next ? 2'b10 : 2'b01);
    end

    always_ff @(posedge clk_i or negedge _reset_i) begin
        if (!_reset_i) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            out_cnt   <= '0;
            burst_cnt <= '0;
            gnt_o     <= 2'b00;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            last      <= last_next;
            out_cnt   <= out_next;
            burst_cnt <= burst_next;
            gnt_o     <= gnt_next;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic against a
// transaction-level model of ownership, burst and outstanding-transfer rules.
module tb_sram_arbiter;
    localparam int MAX_BURST = 8;
    localparam int OUT_W     = 2;
    localparam int LIMIT     = (1 << OUT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic [1:0]  sel [2];
    logic [18:0] adr [2];
    logic [15:0] wdat [2];
    logic        ack_o [2];
    logic [15:0] rdat [2];
    logic        stall [2];
    logic        s_cyc, s_stb, s_we, s_ack, s_stall;
    logic [1:0]  s_sel, gnt;
    logic [18:0] s_adr;
    logic [15:0] s_wdat, s_rdat;

    sram_arbiter #(.MAX_BURST(MAX_BURST), .OUT_W(OUT_W)) dut (
        .clk_i(clk), ._reset_i(rst_n),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
        .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_ack_o(ack_o[0]), .m0_dat_o(rdat[0]),
        .m0_stall_o(stall[0]),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
        .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_ack_o(ack_o[1]), .m1_dat_o(rdat[1]),
        .m1_stall_o(stall[1]),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
        .s_stall_i(s_stall), .gnt_o(gnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the bus, whether it is draining, and the counts.
    int mo_owner;
    bit mo_drain;
    int mo_out, mo_burst, mo_last;
    int acc_cnt [2];
    int ackd [2];
    int obs_acc [2];
    int obs_ack [2];
    bit auto_ack;
    bit last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mo_owner = -1; mo_drain = 0; mo_out = 0; mo_burst = 0; mo_last = 1;
        last_acc = 0;
        for (int n = 0; n < 2; n++) begin
            acc_cnt[n] = 0; ackd[n] = 0; obs_acc[n] = 0; obs_ack[n] = 0;
        end
    endtask

    task automatic model_enter(input int n);
        mo_owner = n; mo_last = n; mo_drain = 0; mo_burst = 0; mo_out = 0;
    endtask

    task automatic model_release();
        mo_owner = -1; mo_drain = 0; mo_out = 0;
    endtask

    task automatic drive_idle();
        for (int n = 0; n < 2; n++) begin
            cyc[n] = 0; stb[n] = 0; we[n] = 0; sel[n] = 2'b00; adr[n] = '0; wdat[n] = '0;
        end
        s_ack = 0; s_stall = 0; s_rdat = '0; auto_ack = 0;
    endtask

    // Compare every output at the falling edge, advance the model, cross the rising edge.
    task automatic step();
        bit act, owncyc, othcyc, yld, hld, estb, acc, eack;
        int o;
        @(negedge clk);
        act    = (mo_owner >= 0);
        o      = act ? mo_owner : 0;
        owncyc = act && cyc[o];
        othcyc = act && cyc[1-o];
        yld    = act && (mo_burst == MAX_BURST) && othcyc;
        hld    = (mo_out == LIMIT) || yld;
        estb   = act && !mo_drain && stb[o] && !hld;
        acc    = estb && !s_stall;
        chk("gnt", 32'(gnt), act ? (o == 1 ? 32'd2 : 32'd1) : 32'd0);
        chk("s_cyc", 32'(s_cyc), 32'(owncyc));
        chk("s_stb", 32'(s_stb), 32'(estb));
        chk("s_we", 32'(s_we), act ? 32'(we[o]) : 32'd0);
        chk("s_sel", 32'(s_sel), act ? 32'(sel[o]) : 32'd0);
        chk("s_adr", 32'(s_adr), act ? 32'(adr[o]) : 32'd0);
        chk("s_dat", 32'(s_wdat), act ? 32'(wdat[o]) : 32'd0);
        for (int n = 0; n < 2; n++) begin
            eack = s_ack && act && (o == n);
            chk($sformatf("stall%0d", n), 32'(stall[n]),
                32'(!(act && !mo_drain && o == n) || s_stall || hld));
            chk($sformatf("ack%0d", n), 32'(ack_o[n]), 32'(eack));
            chk($sformatf("rdat%0d", n), 32'(rdat[n]), eack ? 32'(s_rdat) : 32'd0);
            if (eack) ackd[n]++;
            if (s_stb && !s_stall && gnt[n]) obs_acc[n]++;
            if (ack_o[n]) obs_ack[n]++;
        end
        if (acc) acc_cnt[o]++;
        if (!act) begin
            if (cyc[0] && cyc[1]) model_enter(1 - mo_last);
            else if (cyc[0]) model_enter(0);
            else if (cyc[1]) model_enter(1);
        end else if (!owncyc || (mo_drain && (mo_out == 0 || (mo_out == 1 && s_ack)))) begin
            if (othcyc) model_enter(1 - o);
            else model_release();
        end else begin
            mo_out = mo_out + int'(acc) - int'(s_ack);
            if (mo_out < 0) mo_out = 0;
            if (acc && mo_burst < MAX_BURST) mo_burst++;
            if (yld) mo_drain = 1;
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        if (auto_ack) begin
            s_ack  = last_acc;
            s_rdat = 16'($urandom);
        end
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        bit switched;
        drive_idle();
        model_reset();

        // reset holds everything idle even with a request pending, then 1-cycle grant
        rst_n = 0;
        cyc[0] = 1; stb[0] = 1; adr[0] = 19'h00010;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_stall0", 32'(stall[0]), 32'd1);
        chk("rst_stall1", 32'(stall[1]), 32'd1);
        chk("rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("rst_s_stb", 32'(s_stb), 32'd0);
        rst_n = 1;
        step();
        chk("t1_gnt", 32'(gnt), 32'd1);
        chk("t1_adr", 32'(s_adr), 32'h00010);
        chk("t1_stall0", 32'(stall[0]), 32'd0);

        // single read by m1
        do_reset();
        cyc[1] = 1; stb[1] = 1; adr[1] = 19'h00003; sel[1] = 2'b11;
        step();
        step();
        stb[1] = 0; s_ack = 1; s_rdat = 16'hF00D;
        #1;
        chk("t2_ack1", 32'(ack_o[1]), 32'd1);
        chk("t2_dat1", 32'(rdat[1]), 32'hF00D);
        chk("t2_ack0", 32'(ack_o[0]), 32'd0);
        chk("t2_dat0", 32'(rdat[0]), 32'd0);
        step();
        s_ack = 0;
        #1;
        chk("t2_ack1_off", 32'(ack_o[1]), 32'd0);
        chk("t2_dat1_off", 32'(rdat[1]), 32'd0);
        cyc[1] = 0;
        step();

        // simultaneous requests: m0 first after reset, then m1
        do_reset();
        cyc[0] = 1; cyc[1] = 1;
        step();
        chk("t3_first", 32'(gnt), 32'd1);
        cyc[0] = 0; cyc[1] = 0;
        step();
        chk("t3_idle", 32'(gnt), 32'd0);
        cyc[0] = 1; cyc[1] = 1;
        step();
        chk("t3_second", 32'(gnt), 32'd2);
        chk("t3_stall1", 32'(stall[1]), 32'd0);
        cyc[0] = 0; cyc[1] = 0;
        step();

        // forced yield: m0 streams 20, m1 asks at strobe 2 and does 3 transfers
        do_reset();
        auto_ack = 1;
        switched = 0;
        for (int i = 0; i < 300 && ackd[0] < 20; i++) begin
            cyc[0] = (ackd[0] < 20);
            stb[0] = (acc_cnt[0] < 20);
            adr[0] = 19'(acc_cnt[0]);
            cyc[1] = (acc_cnt[0] >= 2) && (ackd[1] < 3);
            stb[1] = cyc[1] && (acc_cnt[1] < 3);
            adr[1] = 19'h40000 + 19'(acc_cnt[1]);
            step();
            if (!switched && gnt == 2'b10) begin
                switched = 1;
                chk("t4_acc0_at_switch", 32'(obs_acc[0]), 32'd8);
                chk("t4_ack0_at_switch", 32'(obs_ack[0]), 32'd8);
                chk("t4_stall0_at_switch", 32'(stall[0]), 32'd1);
                chk("t4_m1_first_adr", 32'(s_adr), 32'h40000);
            end
        end
        chk("t4_switch_seen", 32'(switched), 32'd1);
        chk("t4_acc0_total", 32'(obs_acc[0]), 32'd20);
        chk("t4_acc1_total", 32'(obs_acc[1]), 32'd3);
        cyc[0] = 0; cyc[1] = 0; stb[0] = 0; stb[1] = 0; auto_ack = 0; s_ack = 0;
        step();

        // backpressure: acks withheld, limit of outstanding transfers
        do_reset();
        cyc[0] = 1; stb[0] = 1;
        repeat (8) step();
        chk("t5_acc_limit", 32'(obs_acc[0]), 32'(LIMIT));
        chk("t5_stalled", 32'(stall[0]), 32'd1);
        s_ack = 1;
        step();
        s_ack = 0;
        repeat (6) step();
        chk("t5_one_more", 32'(obs_acc[0]), 32'(LIMIT + 1));
        cyc[0] = 0; stb[0] = 0;
        step();

        // abort with transfers pending, late ack is dropped
        do_reset();
        cyc[1] = 1; stb[1] = 1;
        for (int i = 0; i < 10 && acc_cnt[1] < 2; i++) step();
        cyc[1] = 0; stb[1] = 0;
        step();
        s_ack = 1; s_rdat = 16'hBEEF;
        #1;
        chk("t6_ack1", 32'(ack_o[1]), 32'd0);
        chk("t6_ack0", 32'(ack_o[0]), 32'd0);
        chk("t6_gnt", 32'(gnt), 32'd0);
        step();
        s_ack = 0;
        cyc[1] = 1; stb[1] = 1;
        repeat (8) step();
        chk("t6_cnt_cleared", 32'(obs_acc[1]), 32'(2 + LIMIT));
        cyc[1] = 0; stb[1] = 0;
        step();

        // random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (cyc[n]) begin
                    if ($urandom_range(15) == 0) cyc[n] = 0;
                end else if ($urandom_range(3) == 0) begin
                    cyc[n] = 1;
                end
                stb[n]  = cyc[n] && ($urandom_range(3) != 0);
                we[n]   = 1'($urandom);
                sel[n]  = 2'($urandom);
                adr[n]  = 19'($urandom);
                wdat[n] = 16'($urandom);
            end
            s_stall = ($urandom_range(3) == 0);
            s_ack   = (mo_out > 0 && $urandom_range(1) == 1) || ($urandom_range(31) == 0);
            s_rdat  = 16'($urandom);
            step();
            if (i == 700) begin
                rst_n = 0;
                #2;
                chk("async_rst_gnt", 32'(gnt), 32'd0);
                chk("async_rst_s_cyc", 32'(s_cyc), 32'd0);
                chk("async_rst_stall0", 32'(stall[0]), 32'd1);
                chk("async_rst_stall1", 32'(stall[1]), 32'd1);
                model_reset();
                @(posedge clk);
                #1;
                rst_n = 1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
